// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller (IDLE/COMPARE/WRITE_BACK/ALLOCATE).
// Define DM_CACHE_STATS_EN to add saturating hit/miss/write-back counters.
module dm_cache_ctrl #(
    parameter int TAGMSB = 31,
    parameter int TAGLSB = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req_valid,
    input  logic                     cpu_req_rw,
    input  logic [31:0]              cpu_req_addr,
    input  logic [31:0]              cpu_req_data,
    output logic                     cpu_res_ready,
    output logic [31:0]              cpu_res_data,
    output logic                     mem_req_valid,
    output logic                     mem_req_rw,
    output logic [31:0]              mem_req_addr,
    output logic [127:0]             mem_req_data,
    input  logic                     mem_res_ready,
    input  logic [127:0]             mem_res_data,
    output logic [9:0]               tag_req_index,
    output logic                     tag_req_we,
    output logic                     tag_write_valid,
    output logic                     tag_write_dirty,
    output logic [TAGMSB-TAGLSB:0]   tag_write_tag,
    input  logic                     tag_read_valid,
    input  logic                     tag_read_dirty,
    input  logic [TAGMSB-TAGLSB:0]   tag_read_tag,
    output logic [9:0]               data_req_index,
    output logic                     data_req_we,
    output logic [127:0]             data_write,
    input  logic [127:0]             data_read
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [31:0]              stat_hits,
    output logic [31:0]              stat_misses,
    output logic [31:0]              stat_writebacks
`endif
);

    localparam int TAG_W = TAGMSB - TAGLSB + 1;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;

    state_t            state;
    logic              req_rw;
    logic [31:0]       req_addr;
    logic [31:0]       req_data;
    logic              retry;

    logic [TAG_W-1:0]  req_tag;
    logic [9:0]        req_index;
    logic [1:0]        req_word;
    logic              in_cmp;
    logic              hit;
    logic              fill;

    assign req_tag   = req_addr[TAGMSB:TAGLSB];
    assign req_index = req_addr[13:4];
    assign req_word  = req_addr[3:2];
    assign in_cmp    = (state == COMPARE);
    assign hit       = tag_read_valid && (tag_read_tag == req_tag);
    assign fill      = (state == ALLOCATE) && mem_req_valid && mem_res_ready;

    function automatic logic [31:0] select_word(input logic [127:0] line, input logic [1:0] sel);
        return line[{sel, 5'd0} +: 32];
    endfunction

    function automatic logic [127:0] merge_word(input logic [127:0] line, input logic [1:0] sel,
                                                input logic [31:0] w);
        logic [127:0] r;
        r = line;
        r[{sel, 5'd0} +: 32] = w;
        return r;
    endfunction

    // Memory request fields are registered so they stay stable for the whole handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            req_rw        <= 1'b0;
            req_addr      <= '0;
            req_data      <= '0;
            retry         <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_rw    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req_valid) begin
                        req_rw   <= cpu_req_rw;
                        req_addr <= cpu_req_addr;
                        req_data <= cpu_req_data;
                        retry    <= 1'b0;
                        state    <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        state <= IDLE;
                    end else begin
                        mem_req_valid <= 1'b1;
                        if (tag_read_valid && tag_read_dirty) begin
                            state        <= WRITE_BACK;
                            mem_req_rw   <= 1'b1;
                            mem_req_addr <= {tag_read_tag, req_index, 4'b0};
                            mem_req_data <= data_read;
                        end else begin
                            state        <= ALLOCATE;
                            mem_req_rw   <= 1'b0;
                            mem_req_addr <= {req_tag, req_index, 4'b0};
                        end
                    end
                end
                WRITE_BACK: begin
                    if (mem_res_ready) begin
                        state        <= ALLOCATE;
                        mem_req_rw   <= 1'b0;
                        mem_req_addr <= {req_tag, req_index, 4'b0};
                    end
                end
                ALLOCATE: begin
                    if (mem_res_ready) begin
                        mem_req_valid <= 1'b0;
                        retry         <= 1'b1;
                        state         <= COMPARE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array-side outputs depend on the same-cycle array read, so they are decoded combinationally
    always_comb begin
        cpu_res_ready   = 1'b0;
        cpu_res_data    = '0;
        data_req_we     = 1'b0;
        data_write      = '0;
        tag_req_we      = 1'b0;
        tag_write_valid = 1'b0;
        tag_write_dirty = 1'b0;
        tag_write_tag   = '0;
        tag_req_index   = (state == IDLE) ? '0 : req_index;
        data_req_index  = (state == IDLE) ? '0 : req_index;
        if (in_cmp && hit) begin
            cpu_res_ready = 1'b1;
            if (req_rw) begin
                data_req_we     = 1'b1;
                data_write      = merge_word(data_read, req_word, req_data);
                tag_req_we      = 1'b1;
                tag_write_valid = 1'b1;
                tag_write_dirty = 1'b1;
                tag_write_tag   = tag_read_tag;
            end else begin
                cpu_res_data = select_word(data_read, req_word);
            end
        end else if (fill) begin
            data_req_we     = 1'b1;
            data_write      = mem_res_data;
            tag_req_we      = 1'b1;
            tag_write_valid = 1'b1;
            tag_write_tag   = req_tag;
        end
    end

`ifdef DM_CACHE_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // The post-refill retry always hits and is excluded from the hit count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hits       <= '0;
            stat_misses     <= '0;
            stat_writebacks <= '0;
        end else if (in_cmp) begin
            if (hit && !retry)
                stat_hits <= sat_inc(stat_hits);
            if (!hit)
                stat_misses <= sat_inc(stat_misses);
            if (!hit && tag_read_valid && tag_read_dirty)
                stat_writebacks <= sat_inc(stat_writebacks);
        end
    end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl: tag/data arrays and memory modelled here, loads checked against a flat memory model.
module tb_dm_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cpu_req_valid, cpu_req_rw;
    logic [31:0]  cpu_req_addr, cpu_req_data;
    logic         cpu_res_ready;
    logic [31:0]  cpu_res_data;
    logic         mem_req_valid, mem_req_rw;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic         mem_res_ready;
    logic [127:0] mem_res_data;
    logic [9:0]   tag_req_index, data_req_index;
    logic         tag_req_we, tag_write_valid, tag_write_dirty;
    logic [17:0]  tag_write_tag, tag_read_tag;
    logic         tag_read_valid, tag_read_dirty;
    logic         data_req_we;
    logic [127:0] data_write, data_read;
`ifdef DM_CACHE_STATS_EN
    logic [31:0]  stat_hits, stat_misses, stat_writebacks;
`endif

    dm_cache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw),
        .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
        .cpu_res_ready(cpu_res_ready), .cpu_res_data(cpu_res_data),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_res_ready(mem_res_ready), .mem_res_data(mem_res_data),
        .tag_req_index(tag_req_index), .tag_req_we(tag_req_we),
        .tag_write_valid(tag_write_valid), .tag_write_dirty(tag_write_dirty),
        .tag_write_tag(tag_write_tag), .tag_read_valid(tag_read_valid),
        .tag_read_dirty(tag_read_dirty), .tag_read_tag(tag_read_tag),
        .data_req_index(data_req_index), .data_req_we(data_req_we),
        .data_write(data_write), .data_read(data_read)
`ifdef DM_CACHE_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_writebacks(stat_writebacks)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Tag and data arrays with combinational read
    logic         tv [1024];
    logic         td [1024];
    logic [17:0]  tt [1024];
    logic [127:0] darr [1024];
    logic         arr_clr = 1'b1;

    assign tag_read_valid = tv[tag_req_index];
    assign tag_read_dirty = td[tag_req_index];
    assign tag_read_tag   = tt[tag_req_index];
    assign data_read      = darr[data_req_index];

    always @(posedge clk) begin
        if (arr_clr) begin
            for (int i = 0; i < 1024; i++) begin
                tv[i] <= 1'b0; td[i] <= 1'b0; tt[i] <= '0; darr[i] <= '0;
            end
        end else begin
            if (tag_req_we) begin
                tv[tag_req_index] <= tag_write_valid;
                td[tag_req_index] <= tag_write_dirty;
                tt[tag_req_index] <= tag_write_tag;
            end
            if (data_req_we) darr[data_req_index] <= data_write;
        end
    end

    // Reference model: CPU-visible memory is a flat word store
    logic [31:0]  fmem [logic [31:0]];
    logic [127:0] bmem [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        return fmem.exists(k) ? fmem[k] : init_word(k);
    endfunction

    function automatic logic [127:0] bmem_rd(input logic [31:0] la);
        if (bmem.exists(la)) return bmem[la];
        return {init_word(la + 12), init_word(la + 8), init_word(la + 4), init_word(la)};
    endfunction

    // Memory slave: responds a chosen number of cycles after the request is seen
    int           fixed_delay = 0;
    int           cnt = -1;
    int           wb_cnt = 0, fetch_cnt = 0;
    logic [31:0]  last_wb_addr = '0, last_fetch_addr = '0;
    logic [127:0] last_wb_data = '0;

    initial begin
        mem_res_ready = 1'b0;
        mem_res_data  = '0;
        forever begin
            @(negedge clk);
            mem_res_ready = 1'b0;
            if (rst) begin
                cnt = -1;
            end else if (mem_req_valid) begin
                if (cnt < 0) cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                if (cnt == 0) begin
                    mem_res_ready = 1'b1;
                    if (mem_req_rw) begin
                        bmem[mem_req_addr] = mem_req_data;
                        last_wb_addr = mem_req_addr;
                        last_wb_data = mem_req_data;
                        wb_cnt++;
                    end else begin
                        mem_res_data = bmem_rd(mem_req_addr);
                        last_fetch_addr = mem_req_addr;
                        fetch_cnt++;
                    end
                    cnt = -1;
                end else begin
                    cnt--;
                end
            end
        end
    end

    typedef struct {
        logic        rw;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    // Response monitor: pops one expectation per completion pulse
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst && cpu_res_ready) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_response actual=1 required=0");
            end else begin
                e = sb.pop_front();
                if (!e.rw) chk("load_data", {96'd0, cpu_res_data}, {96'd0, e.data});
            end
        end
    end

    // Bus monitor: request stability, alignment, exclusivity, pulse counters
    logic         pv = 1'b0, prw = 1'b0, prdy = 1'b0;
    logic [31:0]  pa = '0;
    logic [127:0] pd = '0;
    int           we_cnt = 0, mv_cnt = 0;

    always @(negedge clk) begin
        #2;
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (mem_req_valid) begin
                chk("addr_align", {124'd0, mem_req_addr[3:0]}, 128'd0);
                if (pv && !prdy) begin
                    chk("hold_addr", {96'd0, mem_req_addr}, {96'd0, pa});
                    chk("hold_rw", {127'd0, mem_req_rw}, {127'd0, prw});
                    if (mem_req_rw) chk("hold_data", mem_req_data, pd);
                end
                mv_cnt++;
            end
            if (cpu_res_ready && mem_req_valid) begin
                total++; bad++;
                $display("FAIL res_with_memreq actual=1 required=0");
            end
            if (data_req_we) we_cnt++;
            pv = mem_req_valid; prw = mem_req_rw; pa = mem_req_addr;
            pd = mem_req_data; prdy = mem_res_ready;
        end
    end

    task automatic do_req(input logic rw, input logic [31:0] a, input logic [31:0] d, output int lat);
        exp_t e;
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_rw = rw; cpu_req_addr = a; cpu_req_data = d;
        e.rw = rw;
        e.data = rw ? d : model_rd(a);
        sb.push_back(e);
        if (rw) fmem[{a[31:2], 2'b00}] = d;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        lat = 1;
        while (!cpu_res_ready && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (!cpu_res_ready) begin
            total++; bad++;
            $display("FAIL response_timeout actual=none required=cpu_res_ready addr=%h", a);
        end
    endtask

    task automatic chk_tag(input string n, input logic [9:0] i, input logic v, input logic dty,
                           input logic [17:0] t);
        chk(n, {108'd0, tv[i], td[i], tt[i]}, {108'd0, v, dty, t});
    endtask

    logic [127:0] line0, line1;
    int           lat, w0, m0, f0, b0, waits;
    logic [9:0]   idx_tab [4];

    initial begin
        cpu_req_valid = 1'b0; cpu_req_rw = 1'b0; cpu_req_addr = '0; cpu_req_data = '0;
        idx_tab[0] = 10'h123; idx_tab[1] = 10'h000; idx_tab[2] = 10'h3FF; idx_tab[3] = 10'h2A0;
        repeat (2) @(negedge clk);
        chk("rst_res_ready", {127'd0, cpu_res_ready}, 128'd0);
        chk("rst_res_data", {96'd0, cpu_res_data}, 128'd0);
        chk("rst_mem_valid", {127'd0, mem_req_valid}, 128'd0);
        chk("rst_mem_addr", {96'd0, mem_req_addr}, 128'd0);
        chk("rst_tag_we", {127'd0, tag_req_we}, 128'd0);
        chk("rst_data_we", {127'd0, data_req_we}, 128'd0);
        chk("rst_index", {118'd0, tag_req_index}, 128'd0);
        arr_clr = 1'b0;
        rst = 1'b0;

        // Clean miss on an empty array
        line0 = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        bmem[32'h0000_1230] = line0;
        for (int w = 0; w < 4; w++) fmem[32'h0000_1230 + 32'(w * 4)] = line0[w*32 +: 32];
        f0 = fetch_cnt; b0 = wb_cnt; w0 = we_cnt;
        do_req(1'b0, 32'h0000_1230, 32'h0, lat);
        chk("miss_latency", 128'(lat), 128'd3);
        chk("miss_fetch_addr", {96'd0, last_fetch_addr}, {96'd0, 32'h0000_1230});
        chk("miss_fetch_cnt", 128'(fetch_cnt - f0), 128'd1);
        chk("miss_no_wb", 128'(wb_cnt - b0), 128'd0);
        chk("miss_we_pulses", 128'(we_cnt - w0), 128'd1);
        @(negedge clk);
        chk_tag("miss_tag", 10'h123, 1'b1, 1'b0, 18'h0);

        // Store hit merges one word and marks the line dirty
        m0 = mv_cnt;
        do_req(1'b1, 32'h0000_1234, 32'h55, lat);
        chk("hit_latency", 128'(lat), 128'd1);
        chk("hit_no_memreq", 128'(mv_cnt - m0), 128'd0);
        @(negedge clk);
        line1 = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'h0000_0055, 32'hAAAA_AAAA};
        chk("store_line", darr[10'h123], line1);
        chk_tag("store_tag", 10'h123, 1'b1, 1'b1, 18'h0);

        // Dirty miss: write-back of the modified line, then refill
        f0 = fetch_cnt; b0 = wb_cnt;
        do_req(1'b0, 32'h0000_5230, 32'h0, lat);
        chk("dirty_latency", 128'(lat), 128'd4);
        chk("wb_addr", {96'd0, last_wb_addr}, {96'd0, 32'h0000_1230});
        chk("wb_data", last_wb_data, line1);
        chk("wb_cnt", 128'(wb_cnt - b0), 128'd1);
        chk("refill_addr", {96'd0, last_fetch_addr}, {96'd0, 32'h0000_5230});
        @(negedge clk);
        chk_tag("refill_tag", 10'h123, 1'b1, 1'b0, 18'h1);
`ifdef DM_CACHE_STATS_EN
        chk("stat_hits", {96'd0, stat_hits}, 128'd1);
        chk("stat_misses", {96'd0, stat_misses}, 128'd2);
        chk("stat_writebacks", {96'd0, stat_writebacks}, 128'd1);
`endif

        // Memory stalls the refill for 5 cycles
        fixed_delay = 5;
        w0 = we_cnt; m0 = mv_cnt;
        do_req(1'b0, 32'h0000_2008, 32'h0, lat);
        chk("stall_latency", 128'(lat), 128'd8);
        chk("stall_valid_cycles", 128'(mv_cnt - m0), 128'd6);
        chk("stall_we_pulses", 128'(we_cnt - w0), 128'd1);

        // Asynchronous reset in the middle of a write-back
        fixed_delay = 0;
        do_req(1'b1, 32'h0000_5234, 32'h77, lat);
        fixed_delay = 1000;
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_rw = 1'b0; cpu_req_addr = 32'h0000_1230;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        waits = 0;
        while (!(mem_req_valid && mem_req_rw) && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        chk("wb_reached", {127'd0, mem_req_valid && mem_req_rw}, 128'd1);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_memvalid", {127'd0, mem_req_valid}, 128'd0);
        chk("async_rst_index", {118'd0, tag_req_index}, 128'd0);
        chk("async_rst_res", {127'd0, cpu_res_ready}, 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        fixed_delay = 0;
        do_req(1'b0, 32'h0000_1230, 32'h0, lat);
        chk("post_rst_latency", 128'(lat), 128'd4);

        // Randomized traffic over a few conflicting indices
        fixed_delay = -1;
        for (int n = 0; n < 250; n++) begin
            logic [31:0] a;
            a = ({14'd0, 18'($urandom_range(0, 3))} << 14) |
                ({22'd0, idx_tab[$urandom_range(0, 3)]} << 4) |
                ({30'd0, 2'($urandom_range(0, 3))} << 2);
            do_req(1'($urandom_range(0, 1)), a, $urandom, lat);
        end

        @(negedge clk);
        @(negedge clk);
        chk("sb_empty", 128'(sb.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
